// File: rtl/kyber_pkg.sv
// ---------------------------------------------------------------------------
// kyber_pkg
// Shared constants and types for the ML-KEM key-parsing datapath.
//   KYBER_Q   : coefficient modulus (3329)
//   KYBER_N   : coefficients per polynomial (256)
//   KYBER_ELL : decoded coefficient width in bits (12)
//   coeff_t   : one decoded / reduced coefficient
//   state_t   : control FSM state for the coefficient-walking stages
// ---------------------------------------------------------------------------
package kyber_pkg;

    localparam int KYBER_Q   = 3329;
    localparam int KYBER_N   = 256;
    localparam int KYBER_ELL = 12;

    typedef logic [KYBER_ELL-1:0] coeff_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mod_q_csub.sv
// ---------------------------------------------------------------------------
// mod_q_csub
// Combinational conditional-subtract reduction modulo Q.
// A single subtraction is enough because an ELL-bit input (max 4095) is
// always below 2*Q, so the result always lands in 0..Q-1.
// Ports:
//   c_i   in  [ELL-1:0]  raw coefficient
//   red_o out [ELL-1:0]  c_i mod Q
//   bad_o out 1          c_i was >= Q (out of the canonical range)
// ---------------------------------------------------------------------------
module mod_q_csub
    import kyber_pkg::*;
#(
    parameter int ELL = KYBER_ELL,
    parameter int Q   = KYBER_Q
) (
    input  logic [ELL-1:0] c_i,
    output logic [ELL-1:0] red_o,
    output logic           bad_o
);

    localparam logic [ELL-1:0] Q_W = ELL'(Q);

    // Compare and subtract share the same constant; the mux picks the
    // subtracted value only when the input is out of range.
    always_comb begin
        bad_o = (c_i >= Q_W);
        red_o = bad_o ? (c_i - Q_W) : c_i;
    end

endmodule

// File: rtl/poly_modq_check.sv
// ---------------------------------------------------------------------------
// poly_modq_check
// Walks the decoded coefficients of one polynomial, reduces each modulo Q,
// streams them out over valid/ready with their index, and counts how many
// transferred coefficients were >= Q (encapsulation-key modulus check).
// Ports:
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   start_i     in   begin a pass (honoured only when idle)
//   coeffs_i    in   NUM_COEFFS x ELL decoded coefficients, held stable
//   coeff_o     out  reduced coefficient
//   idx_o       out  index of coeff_o
//   valid_o     out  coeff_o/idx_o valid
//   ready_i     in   downstream accepts
//   busy_o      out  pass in progress (RUN or DONE)
//   done_o      out  one-cycle pulse after the last transfer
//   bad_o       out  sticky: some transferred coefficient was >= Q
//   bad_count_o out  number of transferred coefficients >= Q
// ---------------------------------------------------------------------------
module poly_modq_check
    import kyber_pkg::*;
#(
    parameter int ELL        = KYBER_ELL,
    parameter int NUM_COEFFS = KYBER_N,
    parameter int Q          = KYBER_Q
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start_i,
    input  logic [ELL-1:0]                coeffs_i [NUM_COEFFS],
    output logic [ELL-1:0]                coeff_o,
    output logic [$clog2(NUM_COEFFS)-1:0] idx_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          bad_o,
    output logic [$clog2(NUM_COEFFS):0]   bad_count_o
);

    localparam int              IDXW     = $clog2(NUM_COEFFS);
    localparam int              CNTW     = IDXW + 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_COEFFS - 1);

    state_t            state_q,   state_d;
    logic [ELL-1:0]    coeff_q,   coeff_d;
    logic [IDXW-1:0]   idx_q,     idx_d;
    logic              valid_q,   valid_d;
    logic              cur_bad_q, cur_bad_d;
    logic              bad_q,     bad_d;
    logic [CNTW-1:0]   cnt_q,     cnt_d;

    logic [IDXW-1:0]   sel_idx;
    logic [ELL-1:0]    sel_red;
    logic              sel_bad;
    logic              xfer;

    // The only path from coeffs_i: pick the coefficient that will be loaded
    // into the output register next (index 0 on start, idx+1 on a transfer),
    // then reduce it. After the last index the increment wraps harmlessly;
    // nothing is loaded in that case.
    always_comb begin
        sel_idx = (state_q == IDLE) ? '0 : (idx_q + IDXW'(1));
    end

    mod_q_csub #(
        .ELL (ELL),
        .Q   (Q)
    ) u_csub (
        .c_i   (coeffs_i[sel_idx]),
        .red_o (sel_red),
        .bad_o (sel_bad)
    );

    assign xfer = valid_q && ready_i;

    // Next-state logic. The out-of-range flag is captured together with the
    // reduced value when a coefficient is loaded, so the count at transfer
    // time refers to exactly the coefficient being handed over. Since the
    // source holds coeffs_i stable for the whole pass, this equals checking
    // coeffs_i[idx_o] at the transfer, and each coefficient is counted once
    // however long it stalls.
    always_comb begin
        state_d   = state_q;
        coeff_d   = coeff_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        cur_bad_d = cur_bad_q;
        bad_d     = bad_q;
        cnt_d     = cnt_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d   = RUN;
                    bad_d     = 1'b0;
                    cnt_d     = '0;
                    coeff_d   = sel_red;
                    cur_bad_d = sel_bad;
                    idx_d     = '0;
                    valid_d   = 1'b1;
                end
            end
            RUN: begin
                if (xfer) begin
                    if (cur_bad_q) begin
                        cnt_d = cnt_q + CNTW'(1);
                        bad_d = 1'b1;
                    end
                    if (idx_q == LAST_IDX) begin
                        valid_d = 1'b0;
                        state_d = DONE;
                    end else begin
                        idx_d     = idx_q + IDXW'(1);
                        coeff_d   = sel_red;
                        cur_bad_d = sel_bad;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset clears everything immediately,
    // aborting any pass in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            coeff_q   <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            cur_bad_q <= 1'b0;
            bad_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            coeff_q   <= coeff_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            cur_bad_q <= cur_bad_d;
            bad_q     <= bad_d;
            cnt_q     <= cnt_d;
        end
    end

    assign coeff_o     = coeff_q;
    assign idx_o       = idx_q;
    assign valid_o     = valid_q;
    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == DONE);
    assign bad_o       = bad_q;
    assign bad_count_o = cnt_q;

endmodule

// File: tb/tb_poly_modq_check.sv
// ---------------------------------------------------------------------------
// tb_poly_modq_check
// Self-checking bench for poly_modq_check. A table of passes (coefficient
// pattern, ready behaviour, stray start pulses) is applied back to back; the
// expected reduced stream is queued when a pass starts and popped on every
// observed transfer. Reset at start-up and an abort mid-pass are hand-written.
// ---------------------------------------------------------------------------
module tb_poly_modq_check;

    localparam int N = 256;
    localparam int Q = 3329;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic        ready_i;
    logic [11:0] coeffs [N];
    logic [11:0] coeff_o;
    logic [7:0]  idx_o;
    logic        valid_o;
    logic        busy_o;
    logic        done_o;
    logic        bad_o;
    logic [8:0]  bad_count_o;

    int assertCount = 0;
    int failCount   = 0;

    logic [19:0] expQ [$];
    int          modelBad;

    typedef struct {
        string name;
        int    pattern;
        int    readyMode;
        int    pokeStart;
        int    abortIdx;
        int    expBadCount;
    } vec_t;

    vec_t vecs [6];

    poly_modq_check dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .coeffs_i    (coeffs),
        .coeff_o     (coeff_o),
        .idx_o       (idx_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .bad_o       (bad_o),
        .bad_count_o (bad_count_o)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: count it, report any difference.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference reduction.
    function automatic logic [11:0] modelRed(input logic [11:0] c);
        return (c >= 12'd3329) ? (c - 12'd3329) : c;
    endfunction

    // Coefficient patterns: 0 all zero, 1 boundary values then index, 2 random.
    task automatic fillCoeffs(input int pattern);
        for (int i = 0; i < N; i++) begin
            case (pattern)
                0:       coeffs[i] = 12'd0;
                1:       coeffs[i] = 12'(i);
                default: coeffs[i] = 12'($urandom_range(0, 4095));
            endcase
        end
        if (pattern == 1) begin
            coeffs[0] = 12'd3328;
            coeffs[1] = 12'd3329;
            coeffs[2] = 12'd4095;
        end
    endtask

    // Full reset; leaves the bench at posedge+1 in IDLE.
    task automatic doReset();
        start_i = 1'b0;
        ready_i = 1'b0;
        rst_n   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Run one pass starting from IDLE at posedge+1. Ends at posedge+1 of the
    // first IDLE cycle after DONE, so the next call is back to back.
    task automatic applyStimulus(input vec_t v);
        int          cyc;
        int          expBad;
        bit          poked;
        bit          prevStall;
        logic [11:0] prevCoeff;
        logic [7:0]  prevIdx;
        logic [19:0] e;

        fillCoeffs(v.pattern);
        expQ.delete();
        modelBad = 0;
        for (int i = 0; i < N; i++) begin
            expQ.push_back({8'(i), modelRed(coeffs[i])});
            if (coeffs[i] >= 12'd3329) modelBad++;
        end
        expBad = (v.expBadCount >= 0) ? v.expBadCount : modelBad;

        start_i = 1'b1;
        ready_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        cyc = 1;
        poked = 0;
        prevStall = 0;
        prevCoeff = '0;
        prevIdx = '0;
        checkOutput({v.name, " busy after start"}, 32'(busy_o), 1);
        checkOutput({v.name, " valid after start"}, 32'(valid_o), 1);
        checkOutput({v.name, " bad_count cleared"}, 32'(bad_count_o), 0);

        while (cyc < 3000) begin
            if (done_o) break;
            if (prevStall) begin
                checkOutput({v.name, " coeff stable in stall"}, 32'(coeff_o), 32'(prevCoeff));
                checkOutput({v.name, " idx stable in stall"}, 32'(idx_o), 32'(prevIdx));
            end
            ready_i = (v.readyMode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (v.abortIdx >= 0 && valid_o && int'(idx_o) == v.abortIdx) begin
                rst_n = 1'b0;
                #1;
                checkOutput({v.name, " abort coeff"}, 32'(coeff_o), 0);
                checkOutput({v.name, " abort idx"}, 32'(idx_o), 0);
                checkOutput({v.name, " abort valid"}, 32'(valid_o), 0);
                checkOutput({v.name, " abort busy"}, 32'(busy_o), 0);
                checkOutput({v.name, " abort done"}, 32'(done_o), 0);
                checkOutput({v.name, " abort bad"}, 32'(bad_o), 0);
                checkOutput({v.name, " abort bad_count"}, 32'(bad_count_o), 0);
                @(negedge clk);
                rst_n = 1'b1;
                ready_i = 1'b1;
                @(posedge clk);
                #1;
                checkOutput({v.name, " idle after abort"}, 32'(busy_o), 0);
                checkOutput({v.name, " no valid after abort"}, 32'(valid_o), 0);
                expQ.delete();
                return;
            end
            if (valid_o && ready_i) begin
                if (expQ.size() == 0) begin
                    checkOutput({v.name, " extra transfer"}, 32'(idx_o), 32'hFFFF);
                end else begin
                    e = expQ.pop_front();
                    checkOutput({v.name, " idx"}, 32'(idx_o), 32'(e[19:12]));
                    checkOutput({v.name, " coeff"}, 32'(coeff_o), 32'(e[11:0]));
                end
            end
            if (v.pokeStart != 0 && !poked && valid_o && idx_o == 8'd100) begin
                start_i = 1'b1;
                poked = 1;
            end
            prevStall = valid_o && !ready_i;
            prevCoeff = coeff_o;
            prevIdx   = idx_o;
            @(posedge clk);
            #1;
            start_i = 1'b0;
            cyc++;
        end

        if (!done_o) begin
            checkOutput({v.name, " done within budget"}, 0, 1);
            doReset();
            return;
        end

        if (v.readyMode == 0) checkOutput({v.name, " done cycle"}, 32'(cyc), 257);
        checkOutput({v.name, " all transfers seen"}, 32'(expQ.size()), 0);
        checkOutput({v.name, " busy in done"}, 32'(busy_o), 1);
        checkOutput({v.name, " valid low in done"}, 32'(valid_o), 0);
        checkOutput({v.name, " bad_o"}, 32'(bad_o), (expBad > 0) ? 1 : 0);
        checkOutput({v.name, " bad_count"}, 32'(bad_count_o), 32'(expBad));

        if (v.pokeStart != 0) start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        checkOutput({v.name, " idle after done"}, 32'(busy_o), 0);
        checkOutput({v.name, " done is one pulse"}, 32'(done_o), 0);
        checkOutput({v.name, " valid stays low"}, 32'(valid_o), 0);
        checkOutput({v.name, " bad_count held"}, 32'(bad_count_o), 32'(expBad));
        checkOutput({v.name, " bad_o held"}, 32'(bad_o), (expBad > 0) ? 1 : 0);
    endtask

    // Main sequence: reset checks, table passes, then abort and recovery.
    initial begin
        vec_t abortVec;
        vec_t afterVec;

        vecs[0] = '{"zero",        0, 0, 0, -1,  0};
        vecs[1] = '{"boundary",    1, 0, 0, -1,  2};
        vecs[2] = '{"clean b2b",   0, 0, 0, -1,  0};
        vecs[3] = '{"rand stall",  2, 1, 0, -1, -1};
        vecs[4] = '{"bound stall", 1, 1, 1, -1,  2};
        vecs[5] = '{"rand poke",   2, 0, 1, -1, -1};
        abortVec = '{"abort",      2, 0, 0, 50, -1};
        afterVec = '{"after abort", 2, 0, 0, -1, -1};

        for (int i = 0; i < N; i++) coeffs[i] = 12'd0;
        start_i = 1'b0;
        ready_i = 1'b0;
        rst_n   = 1'b0;
        #12;
        checkOutput("reset coeff", 32'(coeff_o), 0);
        checkOutput("reset idx", 32'(idx_o), 0);
        checkOutput("reset valid", 32'(valid_o), 0);
        checkOutput("reset busy", 32'(busy_o), 0);
        checkOutput("reset done", 32'(done_o), 0);
        checkOutput("reset bad", 32'(bad_o), 0);
        checkOutput("reset bad_count", 32'(bad_count_o), 0);
        doReset();

        for (int t = 0; t < 6; t++) begin
            $display("[TB] pass %0d: %s", t, vecs[t].name);
            applyStimulus(vecs[t]);
        end

        $display("[TB] abort mid-pass");
        applyStimulus(abortVec);
        applyStimulus(afterVec);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/poly_modq_check.md
# poly_modq_check

Sequential stage directly downstream of the combinational 12-bit coefficient decoder in the key-parsing path. It walks the 256 decoded coefficients one per handshake and reduces each modulo q = 3329 with a conditional subtract. It streams the reduced values with their index over a valid/ready interface into polynomial RAM or the NTT loader. It also counts coefficients that were ≥ q, which is the ML-KEM encapsulation-key modulus check.

## Interface
Parameters:
- ELL, 12, coefficient width; must be 12 for the modulus check to be meaningful.
- NUM_COEFFS, 256, coefficients per polynomial.
- Q, 3329, modulus.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start_i  in  1  one-cycle request to process the current coeffs_i; honoured only in IDLE.
- coeffs_i  in  [ELL-1:0] x NUM_COEFFS  decoder output; the source holds it stable from start_i until done_o.
- coeff_o  out  ELL  reduced coefficient, always < Q while valid_o=1.
- idx_o  out  $clog2(NUM_COEFFS)  index of coeff_o (0..255).
- valid_o  out  1  coeff_o/idx_o are valid.
- ready_i  in  1  downstream accepts; a transfer happens when valid_o && ready_i.
- busy_o  out  1  high in RUN and DONE.
- done_o  out  1  one-cycle pulse after the last transfer.
- bad_o  out  1  sticky: at least one transferred coefficient was ≥ Q.
- bad_count_o  out  $clog2(NUM_COEFFS)+1  number of transferred coefficients ≥ Q (0..256).

## Operation
- States:
  - IDLE: wait for start.
  - RUN: stream coefficients.
  - DONE: one cycle, then return to IDLE.
- Transitions:
  - IDLE→RUN on start_i.
  - RUN→DONE on the transfer of idx 255.
  - DONE→IDLE unconditionally.
- Reduction: red(c) = (c ≥ Q) ? c − Q : c.
  - Computed at ELL bits; for c ≤ 4095 the result is always < Q.
  - Examples: 3329→0, 4095→766.
- Out-of-range flag: is_bad(c) = (c ≥ Q).
- Start accepted in IDLE:
  - Clear bad_o and bad_count_o.
  - Load coeff_o=red(coeffs_i[0]), idx_o=0, valid_o=1.
- Transfer in RUN:
  - If is_bad(coeffs_i[idx_o]), increment bad_count_o and set bad_o.
  - If idx_o<255: idx_o+1, and coeff_o=red(coeffs_i[idx_o+1]).
  - If idx_o=255: valid_o=0 and go to DONE.
- No transfer in RUN (ready_i=0): coeff_o, idx_o and valid_o hold unchanged. Once raised, valid_o never drops without a transfer.
- DONE: done_o=1 for exactly this cycle. bad_o and bad_count_o hold their final values until the next accepted start.
- start_i in RUN or DONE is ignored; it has no effect on state, counters or flags.
- bad_count_o increments only on transfers, so each coefficient is counted exactly once regardless of stalls.

## Timing
- Reset value of every output is 0: coeff_o, idx_o, valid_o, busy_o, done_o, bad_o, bad_count_o. State resets to IDLE.
- rst_n asserted mid-run aborts immediately. The next operation requires a new start_i.
- start_i accepted at edge k:
  - valid_o=1 from cycle k+1.
  - busy_o=1 from cycle k+1 through the DONE cycle.
- With ready_i held high: transfers occur in cycles k+1..k+256, done_o=1 in cycle k+257, IDLE in cycle k+258.
- Throughput is 1 coefficient/cycle. Each stalled cycle adds 1 cycle to the total.
- Earliest next start: start_i asserted in the first IDLE cycle (k+258) is accepted. Back-to-back operation has no further gap.
- All outputs are registered. The only combinational path from coeffs_i is through the index mux and reduction into the coeff_o register.

## Structure
- Shared package kyber_pkg: KYBER_Q=3329, KYBER_N=256, coefficient typedef coeff_t (logic [11:0]), and the FSM state enum (IDLE, RUN, DONE).
- One sub-module, mod_q_csub: combinational, ELL-bit input → reduced value plus is_bad flag. It is reused later by the compress/NTT stages.
- The top level holds the FSM, index counter, output register and bad counter.

## Test plan
- All-zero coeffs_i, ready_i=1:
  - 256 transfers, coeff_o=0, idx_o 0..255 in order.
  - done_o at k+257, bad_o=0, bad_count_o=0.
- coeffs_i[0]=3328, [1]=3329, [2]=4095, rest = index value i:
  - Outputs 3328, 0, 766, then i for i ≥ 3.
  - bad_count_o=2 and bad_o=1 after done_o.
- Pseudo-random ready_i (50% duty) over random 12-bit coeffs:
  - Sequence matches the reference model with no drops or duplicates.
  - coeff_o/idx_o are stable while valid_o && !ready_i.
  - bad_count_o equals the model's count.
- start_i pulsed at idx 100 and again during DONE: ignored; counts and sequence are unchanged.
- rst_n low at idx 50:
  - All outputs 0 asynchronously, state IDLE.
  - A new start yields a complete, correct 256-coefficient run with bad_count_o restarted at 0.
- Two operations back-to-back (start_i in cycle k+258), the first with bad coefficients and the second clean: the second run's bad_o/bad_count_o read 0 at its done_o.
